// File: rtl/apple_generate_module.sv
// apple_generate_module: snake-game apple placement; LFSR-driven relocation after each eat.
// Optional idle relocation enabled by defining APPLE_TIMEOUT_EN.
module apple_generate_module #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic [5:0] Head_x,
  input  logic [5:0] Head_y,
  output logic [5:0] Apple_x,
  output logic [4:0] Apple_y,
  output logic       Apple_type,
  output logic       Body_add_sig
);
  typedef enum logic [1:0] {IDLE, GROW, SEARCH} state_t;
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic [5:0] cand_x;
  logic [4:0] cand_y;
  logic grow_cnt, grow_cnt_nx, match, accept, timeout;
  assign cand_x = lfsr[5:0];
  assign cand_y = lfsr[12:8];
  assign match = Head_x == Apple_x && !Head_y[5] && Head_y[4:0] == Apple_y;
  // Border cells and the head's own cell are never offered as a new apple.
  assign accept = cand_x != 6'd0 && int'(cand_x) <= GRID_W - 2 && cand_y != 5'd0 &&
                  int'(cand_y) <= GRID_H - 2 && !(cand_x == Head_x && cand_y == Head_y[4:0]);
`ifdef APPLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  assign timeout = idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge Clk_50mhz or posedge Rst_n)
    if (Rst_n) idle_cnt <= '0;
    else idle_cnt <= (state == IDLE && state_nx == IDLE) ? idle_cnt + 1'b1 : '0;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  // A golden apple keeps GROW for a second cycle.
  assign grow_cnt_nx = state == GROW && !grow_cnt && Apple_type;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = match ? GROW : timeout ? SEARCH : IDLE;
      GROW:    state_nx = grow_cnt_nx ? GROW : SEARCH;
      SEARCH:  state_nx = accept ? IDLE : SEARCH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk_50mhz or posedge Rst_n) begin
    if (Rst_n) begin
      state <= IDLE;
      lfsr <= 16'hACE1;
      grow_cnt <= 1'b0;
      Apple_x <= 6'd24;
      Apple_y <= 5'd10;
      Apple_type <= 1'b0;
      Body_add_sig <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      grow_cnt <= grow_cnt_nx;
      Body_add_sig <= state_nx == GROW;
      if (state == SEARCH && accept) begin
        Apple_x <= cand_x;
        Apple_y <= cand_y;
        Apple_type <= lfsr[3:0] == 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_apple_generate_module.sv
// tb_apple_generate_module: random head stimulus scored against a transaction-level apple model.
module tb_apple_generate_module;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] head_x, head_y, apple_x;
  logic [4:0] apple_y;
  logic apple_type, body;
  int n_cmp = 0, n_bad = 0;
  logic [12:0] q[$];
  logic [15:0] m_lfsr;
  logic [5:0] m_x;
  logic [4:0] m_y;
  logic m_t, m_b, srch;
  int grow_left, idle_cnt;

  apple_generate_module #(.GRID_W(GW), .GRID_H(GH), .TIMEOUT_CYCLES(TO)) dut (
    .Clk_50mhz(clk), .Rst_n(rst), .Head_x(head_x), .Head_y(head_y),
    .Apple_x(apple_x), .Apple_y(apple_y), .Apple_type(apple_type), .Body_add_sig(body));

  always #10 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic bit placeable(input logic [15:0] v, input logic [5:0] hx, input logic [5:0] hy);
    int x, y;
    x = int'(v[5:0]);
    y = int'(v[12:8]);
    return x >= 1 && x <= GW - 2 && y >= 1 && y <= GH - 2 && !(x == int'(hx) && y == int'(hy[4:0]));
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the apple and the number of growth strobes owed per eat.
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr = 16'hACE1; m_x = 6'd24; m_y = 5'd10; m_t = 1'b0; m_b = 1'b0;
      srch = 1'b0; grow_left = 0; idle_cnt = 0;
    end else begin
      m_b = 1'b0;
      if (srch) begin
        idle_cnt = 0;
        if (placeable(m_lfsr, head_x, head_y)) begin
          m_x = m_lfsr[5:0]; m_y = m_lfsr[12:8]; m_t = m_lfsr[3:0] == 4'd0; srch = 1'b0;
        end
      end else if (grow_left > 0) begin
        grow_left--;
        m_b = grow_left > 0;
        srch = grow_left == 0;
      end else if (head_x == m_x && !head_y[5] && head_y[4:0] == m_y) begin
        grow_left = m_t ? 2 : 1;
        m_b = 1'b1;
        idle_cnt = 0;
      end else begin
`ifdef APPLE_TIMEOUT_EN
        if (idle_cnt == TO - 1) begin
          srch = 1'b1;
          idle_cnt = 0;
        end else idle_cnt++;
`endif
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    q.push_back({m_x, m_y, m_t, m_b});
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("reset_outputs", {apple_x, apple_y, apple_type, body}, {6'd24, 5'd10, 1'b0, 1'b0});
    end else if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
    end else chk("cycle", {apple_x, apple_y, apple_type, body}, q.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (srch || grow_left > 0); i++) tick();
    if (srch || grow_left > 0) chk("idle_timeout", 13'd1, 13'd0);
  endtask

  task automatic eat(output int n);
    head_x = m_x;
    head_y = {1'b0, m_y};
    tick();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (body) n++;
    end
    #2;
    wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    head_x = 6'd28; head_y = 6'd13;
    repeat (5) tick();
    rst = 1'b0;
    repeat (100) tick();
    eat(n);
    chk("normal_strobes", 13'(n), 13'd1);
    head_x = 6'd30; head_y = 6'd14; tick();
    head_x = 6'd25; head_y = 6'd15; tick();
    head_x = 6'd28; head_y = 6'd16; tick();
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0, 1: begin head_x = m_x; head_y = {1'b0, m_y}; end
        2: begin head_x = m_x; head_y = {1'b1, m_y}; end
        default: begin head_x = 6'($urandom_range(0, 63)); head_y = 6'($urandom_range(0, 63)); end
      endcase
      tick();
    end
    wait_idle();
    for (int i = 0; i < 600 && !m_t; i++) eat(n);
    if (!m_t) chk("golden_found", 13'd0, 13'd1);
    else begin
      eat(n);
      chk("golden_strobes", 13'(n), 13'd2);
    end
    head_x = m_x; head_y = {1'b0, m_y};
    tick();
    for (int i = 0; i < 50 && !srch; i++) tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset", {apple_x, apple_y, apple_type, body}, {6'd24, 5'd10, 1'b0, 1'b0});
    repeat (3) tick();
    rst = 1'b0;
    head_x = 6'd5; head_y = 6'd5;
    repeat (20) tick();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin head_x = m_x; head_y = {1'b0, m_y}; end
      else begin head_x = 6'($urandom_range(0, 63)); head_y = 6'($urandom_range(0, 40)); end
      tick();
    end
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apple_generate_module.md
APPLE_GENERATE_MODULE -- requirements
Module: apple_generate_module

Interface
REQ-001 SHALL have parameter GRID_W, default 40, playfield columns; legal x 0..GRID_W-1.
REQ-002 SHALL have parameter GRID_H, default 30, playfield rows; legal y 0..GRID_H-1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 25_000_000, idle cycles before auto-relocation (used only with APPLE_TIMEOUT_EN).
REQ-004 SHALL have port Clk_50mhz, input, 1 bit: the single clock, all state on its rising edge.
REQ-005 SHALL have port Rst_n, input, 1 bit: asynchronous, active-high reset (asserted = 1 despite the name).
REQ-006 SHALL have port Head_x, input, 6 bits: snake head column.
REQ-007 SHALL have port Head_y, input, 6 bits: snake head row; only bits [4:0] compared, bit 5 set means off-grid (never matches).
REQ-008 SHALL have port Apple_x, output, 6 bits: current apple column, registered.
REQ-009 SHALL have port Apple_y, output, 5 bits: current apple row, registered.
REQ-010 SHALL have port Apple_type, output, 1 bit: 0 normal apple, 1 golden apple, registered.
REQ-011 SHALL have port Body_add_sig, output, 1 bit: body-growth strobe, registered.

Function
REQ-012 SHALL run a free-running 16-bit maximal Fibonacci LFSR (taps 16,14,13,11), advancing every cycle, never reaching zero.
REQ-013 SHALL use states IDLE, GROW, SEARCH.
REQ-014 In IDLE, a match (Head_x==Apple_x, Head_y[5]==0, Head_y[4:0]==Apple_y) SHALL move to GROW next cycle.
REQ-015 GROW SHALL drive Body_add_sig=1 for 1 cycle if Apple_type=0, 2 consecutive cycles if Apple_type=1, then enter SEARCH.
REQ-016 SEARCH SHALL form candidate x=LFSR[5:0], y=LFSR[12:8] each cycle and accept it only if 1<=x<=GRID_W-2, 1<=y<=GRID_H-2 and (x,y)!=(Head_x,Head_y[4:0]); otherwise retry next cycle.
REQ-017 On acceptance SHALL load Apple_x/Apple_y, set Apple_type=1 iff LFSR[3:0]==0, and return to IDLE.
REQ-018 Apple outputs SHALL hold their old values until acceptance; match detection SHALL be ignored outside IDLE.
REQ-019 Body_add_sig SHALL be 0 in IDLE and SEARCH; a head resting on the new apple cannot occur (REQ-016), so one arrival yields exactly one growth event.
REQ-020 Head inputs SHALL be sampled synchronously, no other filtering; Head_y>=32 never matches.

Reset
REQ-021 While Rst_n=1: Apple_x=24, Apple_y=10, Apple_type=0, Body_add_sig=0, state IDLE, LFSR=16'hACE1, timeout counter 0.
REQ-022 Reset asserted mid-GROW or mid-SEARCH SHALL abort immediately to REQ-021 values; first match check is the first edge after release.

Configuration
REQ-023 With macro APPLE_TIMEOUT_EN defined, a counter SHALL count IDLE cycles, clear on every transition out of IDLE, and on reaching TIMEOUT_CYCLES-1 force SEARCH without asserting Body_add_sig.
REQ-024 Without APPLE_TIMEOUT_EN, no counter SHALL exist and the apple moves only after being eaten.

Verification
REQ-025 Reset held 100 ns with head (28,13), release -> apple stays (24,10), type 0, Body_add_sig never asserts for 2000 ns.
REQ-026 Head driven to (24,10) -> Body_add_sig high exactly one cycle, then apple moves to a position within x 1..38, y 1..28, not (24,10).
REQ-027 Head moved (30,14)->(25,15)->(28,16), none equal to apple -> no strobe, apple unchanged.
REQ-028 Force a golden apple (repeat eats until Apple_type=1), eat it -> Body_add_sig high exactly two consecutive cycles.
REQ-029 Assert Rst_n during SEARCH -> outputs return to (24,10), type 0, strobe 0 within the same cycle.
REQ-030 APPLE_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, head away from apple -> apple relocates 50 cycles after entering IDLE, Body_add_sig stays 0.
